// File: rtl/csel_adder_pipe.sv
// csel_adder_pipe
//   Pipelined carry-select adder/subtractor with valid/ready handshaking.
//   The operand width is split into NBLK = WIDTH/BLOCK blocks. Each pipeline
//   stage resolves NBLK/STAGES of those blocks. A block computes two ripple
//   sums, one with carry-in 0 and one with carry-in 1, and the running carry
//   selects between them.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   operands presented this cycle
//   in_ready   block accepts operands this cycle
//   a, b       operands (WIDTH bits)
//   cin        carry in, ignored when sub=1
//   sub        0: a+b+cin, 1: a-b
//   out_valid  result valid
//   out_ready  consumer accepts the result
//   sum        result modulo 2^WIDTH
//   cout       carry out of the MSB (for sub, 1 means no borrow)
//   ovf        signed overflow
module csel_adder_pipe #(
  parameter int WIDTH  = 32,
  parameter int BLOCK  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NBLK = WIDTH / BLOCK;
  localparam int BPS  = NBLK / STAGES;   // blocks resolved per stage
  localparam int SW   = BPS * BLOCK;     // bits resolved per stage

  if (((WIDTH % BLOCK) != 0) || ((NBLK % STAGES) != 0)) begin : g_param_err
    $error("csel_adder_pipe: WIDTH must be a multiple of BLOCK and NBLK a multiple of STAGES");
  end

  function automatic logic [BLOCK:0] ripple(input logic [BLOCK-1:0] x,
                                            input logic [BLOCK-1:0] y,
                                            input logic             ci);
    logic             c;
    logic [BLOCK-1:0] s;
    c = ci;
    s = '0;
    for (int i = 0; i < BLOCK; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    return {c, s};
  endfunction

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    // Operand bits still unresolved on entry to this stage. Only these bits
    // travel down the pipe, so the operand registers shrink stage by stage.
    localparam int RWI = WIDTH - k * SW;

    logic [RWI-1:0]        sa, sb;
    logic                  sc, sv;
    logic [SW-1:0]         nb;
    logic                  nc;
    logic [(k+1)*SW-1:0]   ns;
    logic                  rdy;
    logic                  v_r;
    logic [(k+1)*SW-1:0]   s_r;
    logic                  c_r;

    if (k == 0) begin : g_src
      // Subtraction is folded in here: invert b and force the carry to 1.
      assign sa = a;
      assign sb = sub ? ~b : b;
      assign sc = sub | cin;
      assign sv = in_valid;
      assign ns = nb;
    end else begin : g_src
      assign sa = g_stg[k-1].g_ops.a_r;
      assign sb = g_stg[k-1].g_ops.b_r;
      assign sc = g_stg[k-1].c_r;
      assign sv = g_stg[k-1].v_r;
      assign ns = {nb, g_stg[k-1].s_r};
    end

    // A stage can load when it is empty or its contents move on this cycle.
    if (k == STAGES - 1) begin : g_rdy
      assign rdy = !v_r | out_ready;
    end else begin : g_rdy
      assign rdy = !v_r | g_stg[k+1].rdy;
    end

    always_comb begin
      logic             cc;
      logic [BLOCK:0]   r0, r1;
      nb = '0;
      cc = sc;
      r0 = '0;
      r1 = '0;
      for (int j = 0; j < BPS; j++) begin
        r0 = ripple(sa[j*BLOCK +: BLOCK], sb[j*BLOCK +: BLOCK], 1'b0);
        r1 = ripple(sa[j*BLOCK +: BLOCK], sb[j*BLOCK +: BLOCK], 1'b1);
        nb[j*BLOCK +: BLOCK] = cc ? r1[BLOCK-1:0] : r0[BLOCK-1:0];
        cc = cc ? r1[BLOCK] : r0[BLOCK];
      end
      nc = cc;
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        v_r <= 1'b0;
        s_r <= '0;
        c_r <= 1'b0;
      end else if (rdy) begin
        v_r <= sv;
        if (sv) begin
          s_r <= ns;
          c_r <= nc;
        end
      end
    end

    if (k < STAGES - 1) begin : g_ops
      logic [RWI-SW-1:0] a_r, b_r;
      always_ff @(posedge clk) begin
        if (rst) begin
          a_r <= '0;
          b_r <= '0;
        end else if (rdy && sv) begin
          a_r <= sa[RWI-1:SW];
          b_r <= sb[RWI-1:SW];
        end
      end
    end else begin : g_last
      // Carry into the MSB equals a^b^sum at the MSB, so overflow reduces to
      // a^b^sum^cout at that bit.
      logic ovf_r;
      always_ff @(posedge clk) begin
        if (rst) begin
          ovf_r <= 1'b0;
        end else if (rdy && sv) begin
          ovf_r <= sa[SW-1] ^ sb[SW-1] ^ nb[SW-1] ^ nc;
        end
      end
    end
  end

  assign in_ready  = g_stg[0].rdy;
  assign out_valid = g_stg[STAGES-1].v_r;
  assign sum       = g_stg[STAGES-1].s_r;
  assign cout      = g_stg[STAGES-1].c_r;
  assign ovf       = g_stg[STAGES-1].g_last.ovf_r;

endmodule

// File: tb/tb_csel_adder_pipe.sv
// tb_csel_adder_pipe
//   Self-checking bench for csel_adder_pipe (WIDTH=32, BLOCK=4, STAGES=2).
//   Accepted operands push a model result into a queue; consumed results pop
//   and compare in order.
module tb_csel_adder_pipe;

  localparam int W  = 32;
  localparam int BL = 4;
  localparam int ST = 2;

  logic          clk;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          cin;
  logic          sub;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  sum;
  logic          cout;
  logic          ovf;

  int n_chk = 0;
  int n_bad = 0;

  logic [W+1:0] exp_q[$];
  logic [W+1:0] e_m;

  csel_adder_pipe #(.WIDTH(W), .BLOCK(BL), .STAGES(ST)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // {ovf, cout, sum}
  function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic ci, input logic s);
    logic [W-1:0] yy;
    logic [W:0]   full;
    logic         o;
    yy   = s ? ~y : y;
    full = {1'b0, x} + {1'b0, yy} + {{W{1'b0}}, (s ? 1'b1 : ci)};
    o    = (x[W-1] == yy[W-1]) && (full[W-1] != x[W-1]);
    return {o, full};
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          chk("stale_result_q", exp_q.size(), 1);
        end else begin
          e_m = exp_q.pop_front();
          chk("sb_sum", sum, e_m[W-1:0]);
          chk("sb_cout", cout, e_m[W]);
          chk("sb_ovf", ovf, e_m[W+1]);
        end
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
    end
  end

  // Single op into an empty pipe with out_ready=1; checks latency and result.
  task automatic run_one(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                         input logic xs, input logic [W-1:0] es, input logic ec, input logic eo,
                         input string tag);
    int  lat;
    bit  got;
    a = xa; b = xb; cin = xc; sub = xs; in_valid = 1'b1;
    lat = 0; got = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat++;
      if (out_valid) got = 1;
    end
    chk({tag, "_lat"}, lat, ST);
    chk({tag, "_sum"}, sum, es);
    chk({tag, "_cout"}, cout, ec);
    chk({tag, "_ovf"}, ovf, eo);
    @(posedge clk); #1;
  endtask

  task automatic send(input logic [W-1:0] xa, input logic [W-1:0] xb, input logic xc,
                      input logic xs);
    bit ok;
    a = xa; b = xb; cin = xc; sub = xs; in_valid = 1'b1;
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (in_ready) ok = 1;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("send_accept", ok, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) begin
      @(posedge clk); #1;
    end
    chk("drain_empty", exp_q.size(), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W-1:0] ops_a [6];
    logic [W-1:0] ops_b [6];
    logic [W-1:0] hold_sum;
    logic         hold_c, hold_o;

    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_cout", cout, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_in_ready", in_ready, 1);

    // Basic add, full carry chain, subtract
    run_one(32'h0000_0005, 32'h0000_0003, 1'b0, 1'b0, 32'h0000_0008, 1'b0, 1'b0, "add");
    run_one(32'hFFFF_FFFF, 32'h0000_0000, 1'b1, 1'b0, 32'h0000_0000, 1'b1, 1'b0, "chain");
    run_one(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, "povf");
    run_one(32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, "sub");
    run_one(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, "subovf");

    // Back-pressure: two ops fill the pipe, then stall for 4 cycles
    for (int i = 0; i < 6; i++) begin
      ops_a[i] = 32'h1000_0000 * (i + 1) + 32'h0FFF_FFF0;
      ops_b[i] = 32'h0000_0011 * (i + 3);
    end
    out_ready = 1'b0;
    send(ops_a[0], ops_b[0], 1'b0, 1'b0);
    send(ops_a[1], ops_b[1], 1'b1, 1'b0);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    hold_sum = sum; hold_c = cout; hold_o = ovf;
    a = ops_a[2]; b = ops_b[2]; cin = 1'b0; sub = 1'b1; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("bp_stall_in_ready", in_ready, 0);
      chk("bp_stall_valid", out_valid, 1);
      chk("bp_stall_sum", sum, hold_sum);
      chk("bp_stall_flags", {cout, ovf}, {hold_c, hold_o});
    end
    out_ready = 1'b1;
    for (int i = 2; i < 6; i++) send(ops_a[i], ops_b[i], i[0], (i == 2));
    drain();

    // Reset with two ops in flight
    out_ready = 1'b0;
    send(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0);
    send(32'hDEAD_BEEF, 32'h0000_0001, 1'b1, 1'b0);
    rst = 1'b1;
    exp_q.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_sum", sum, 0);
    chk("mid_rst_cout", cout, 0);
    chk("mid_rst_ovf", ovf, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    out_ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    chk("mid_rst_no_emit", exp_q.size(), 0);

    // Random traffic with random stalls
    for (int i = 0; i < 4000; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      case ($urandom_range(0, 7))
        0:       begin a = 32'hFFFF_FFFF; b = $urandom_range(0, 3); end
        1:       begin a = 32'h7FFF_FFFF; b = $urandom_range(0, 3); end
        2:       begin a = 32'h8000_0000; b = $urandom; end
        default: begin a = $urandom; b = $urandom; end
      endcase
      cin       = $urandom_range(0, 1);
      sub       = $urandom_range(0, 1);
      out_ready = ($urandom_range(0, 3) != 0);
      @(posedge clk); #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
